// File: rtl/cpu_debug_sequencer.sv
// Command front end for the CPU debug/test port: turns single command words
// into memory/register accesses with readback, or a bounded instruction run.
module cpu_debug_sequencer #(
    parameter int ACCESS_CYCLES = 2,
    parameter int RUN_TIMEOUT   = 65535
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [15:0] cmd_addr,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    output logic [15:0] rsp_data,
    output logic [1:0]  rsp_status,
    output logic        busy,
    output logic        cpu_reset,
    output logic        cpu_test,
    output logic        memoryoperation,
    output logic        registeroperation,
    output logic        memorywrite,
    output logic        registerwrite,
    output logic [15:0] memaddress,
    output logic [15:0] memwritedata,
    output logic [15:0] regwritedata,
    output logic [15:0] resetpc,
    output logic [3:0]  registeraddress,
    input  logic [15:0] cpu_RD,
    input  logic [15:0] cpu_MD,
    input  logic [15:0] cpu_PC,
    input  logic [9:1]  cpu_state
);

    typedef enum logic [2:0] {IDLE, ACCESS, SAMPLE, RST_CPU, RUN, RESP} state_t;

    localparam logic [2:0] OP_NOP  = 3'd0;
    localparam logic [2:0] OP_WMEM = 3'd1;
    localparam logic [2:0] OP_RMEM = 3'd2;
    localparam logic [2:0] OP_WREG = 3'd3;
    localparam logic [2:0] OP_RREG = 3'd4;
    localparam logic [2:0] OP_RUN  = 3'd5;

    state_t      state;
    logic [2:0]  op_q;
    logic [15:0] data_q;
    logic [15:0] acc_cnt;
    logic [16:0] fetch_cnt;
    logic [31:0] tmo_cnt;
    logic        prev_fetch;

    logic        is_fetch, fetch_edge, is_mem, is_wr;
    logic [15:0] readback;

    assign is_fetch   = (cpu_state == 9'd1);
    assign fetch_edge = is_fetch && !prev_fetch;
    assign is_mem     = (op_q == OP_WMEM) || (op_q == OP_RMEM);
    assign is_wr      = (op_q == OP_WMEM) || (op_q == OP_WREG);
    assign readback   = is_mem ? cpu_MD : cpu_RD;
    assign cmd_ready  = (state == IDLE);
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            op_q              <= '0;
            data_q            <= '0;
            acc_cnt           <= '0;
            fetch_cnt         <= '0;
            tmo_cnt           <= '0;
            prev_fetch        <= 1'b0;
            rsp_valid         <= 1'b0;
            rsp_data          <= '0;
            rsp_status        <= '0;
            cpu_reset         <= 1'b0;
            cpu_test          <= 1'b0;
            memoryoperation   <= 1'b0;
            registeroperation <= 1'b0;
            memorywrite       <= 1'b0;
            registerwrite     <= 1'b0;
            memaddress        <= '0;
            memwritedata      <= '0;
            regwritedata      <= '0;
            resetpc           <= '0;
            registeraddress   <= '0;
        end else begin
            prev_fetch <= is_fetch;
            rsp_valid  <= 1'b0;
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q    <= cmd_op;
                    data_q  <= cmd_data;
                    acc_cnt <= '0;
                    case (cmd_op)
                        OP_WMEM, OP_RMEM: begin
                            memoryoperation <= 1'b1;
                            memorywrite     <= (cmd_op == OP_WMEM);
                            memaddress      <= cmd_addr;
                            memwritedata    <= cmd_data;
                            state           <= ACCESS;
                        end
                        OP_WREG, OP_RREG: begin
                            registeroperation <= 1'b1;
                            registerwrite     <= (cmd_op == OP_WREG);
                            registeraddress   <= cmd_addr[3:0];
                            regwritedata      <= cmd_data;
                            state             <= ACCESS;
                        end
                        OP_RUN: begin
                            cpu_test  <= 1'b0;
                            cpu_reset <= 1'b1;
                            resetpc   <= cmd_addr;
                            state     <= RST_CPU;
                        end
                        OP_NOP: begin
                            rsp_valid  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_status <= 2'd0;
                            state      <= RESP;
                        end
                        default: begin
                            rsp_valid  <= 1'b1;
                            rsp_data   <= '0;
                            rsp_status <= 2'd3;
                            state      <= RESP;
                        end
                    endcase
                end
                ACCESS: begin
                    acc_cnt <= acc_cnt + 16'd1;
                    if (acc_cnt == 16'(ACCESS_CYCLES - 1)) begin
                        memorywrite   <= 1'b0;
                        registerwrite <= 1'b0;
                        state         <= SAMPLE;
                    end
                end
                SAMPLE: begin
                    memoryoperation   <= 1'b0;
                    registeroperation <= 1'b0;
                    rsp_data          <= readback;
                    rsp_status        <= (is_wr && readback != data_q) ? 2'd1 : 2'd0;
                    rsp_valid         <= 1'b1;
                    state             <= RESP;
                end
                RST_CPU: begin
                    cpu_reset  <= 1'b0;
                    cpu_test   <= 1'b1;
                    fetch_cnt  <= {1'b0, data_q} + 17'd1;
                    tmo_cnt    <= '0;
                    // the CPU may already sit in fetch out of reset; count that as an entry
                    prev_fetch <= 1'b0;
                    state      <= RUN;
                end
                RUN: begin
                    tmo_cnt <= tmo_cnt + 32'd1;
                    if (fetch_edge && fetch_cnt == 17'd1) begin
                        cpu_test   <= 1'b0;
                        rsp_data   <= cpu_PC;
                        rsp_status <= 2'd0;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (tmo_cnt == 32'(RUN_TIMEOUT - 1)) begin
                        cpu_test   <= 1'b0;
                        rsp_data   <= cpu_PC;
                        rsp_status <= 2'd2;
                        rsp_valid  <= 1'b1;
                        state      <= RESP;
                    end else if (fetch_edge) begin
                        fetch_cnt <= fetch_cnt - 17'd1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_debug_sequencer.md
Name: cpu_debug_sequencer

Overview:
- Command-driven front end for the debug/test port of the 16-bit multicycle CPU top (SystemTest). It sits directly upstream of that port and feeds it.
- It turns single command words into the port protocol:
  - memory write with readback verify
  - memory read
  - register write with readback verify
  - register read
  - controlled run: reset to a PC, execute N instructions, halt
- It lets a host link or the on-board controller replace the simulation-only stimulus tasks.

Parameters:
- ACCESS_CYCLES, 2, clock edges the operation/write strobes are held before sampling RD/MD.
- RUN_TIMEOUT, 65535, maximum cycles in a run before abort.

Ports:
- clk  in  1  system clock, all logic on rising edge
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command (IDLE only)
- cmd_op  in  3  0 NOP, 1 WMEM, 2 RMEM, 3 WREG, 4 RREG, 5 RUN, 6-7 illegal
- cmd_addr  in  16  memory address, register index (bits 3:0), or start PC for RUN
- cmd_data  in  16  write data, or instruction count for RUN
- rsp_valid  out  1  one-cycle pulse, response available
- rsp_data  out  16  read data / readback value / final PC
- rsp_status  out  2  0 OK, 1 verify mismatch, 2 run timeout, 3 illegal op
- busy  out  1  high whenever state is not IDLE
- cpu_reset  out  1  to CPU reset
- cpu_test  out  1  to CPU test (run enable)
- memoryoperation, registeroperation, memorywrite, registerwrite  out  1 each  to the CPU debug port
- memaddress, memwritedata, regwritedata, resetpc  out  16 each  to the CPU debug port
- registeraddress  out  4  to the CPU debug port
- cpu_RD, cpu_MD, cpu_PC  in  16 each  from the CPU
- cpu_state  in  9 (bits 9:1)  CPU control state; value 1 means fetch

Behaviour:
- Reset (asynchronous) forces:
  - state IDLE
  - all CPU-port strobes 0; cpu_test 0; cpu_reset 0
  - all address/data outputs 0
  - rsp_valid 0, rsp_data 0, rsp_status 0, busy 0, cmd_ready 1
- Reset asserted mid-operation abandons the operation; no response is emitted.
- FSM states: IDLE, ACCESS, SAMPLE, RST_CPU, RUN, RESP.
- IDLE:
  - cmd_ready = 1.
  - On cmd_valid, latch op/addr/data.
  - NOP and illegal go to RESP (status 0 for NOP, status 3 for illegal).
  - WMEM/RMEM/WREG/RREG go to ACCESS.
  - RUN goes to RST_CPU.
- ACCESS:
  - Drive the operation strobe, the address, and for writes the write strobe plus data, for exactly ACCESS_CYCLES cycles.
  - Then go to SAMPLE.
- SAMPLE:
  - Write strobe drops; the operation strobe is held one more cycle.
  - rsp_data = cpu_MD (memory ops) or cpu_RD (register ops).
  - For writes, status is 1 if the readback differs from the latched data, else 0.
  - Go to RESP.
- RST_CPU:
  - cpu_test = 0, cpu_reset = 1, resetpc = latched addr, for 1 cycle.
  - Load the fetch counter with count + 1 (17-bit, so count 16'hFFFF is legal).
  - Clear the timeout counter.
  - Go to RUN.
- RUN:
  - cpu_reset = 0, cpu_test = 1.
  - A fetch is the cycle where cpu_state == 1 and the previous-cycle cpu_state != 1 (entry detect).
  - Each fetch decrements the counter. When it reaches 0 (on that same fetch), drop cpu_test the next cycle, set rsp_data = cpu_PC, status 0, go to RESP.
  - If the timeout counter reaches RUN_TIMEOUT first: drop cpu_test, status 2, rsp_data = cpu_PC, go to RESP.
  - With count = 0, the run halts at the first fetch after reset, so PC = start PC (fetch not completed).
- RESP: rsp_valid = 1 for exactly one cycle, then IDLE.
- A back-to-back command is accepted the cycle after RESP.
- cmd_valid while busy is ignored; the command must be held until cmd_ready.
- Only one of memoryoperation and registeroperation is ever high. Neither is high while cpu_test = 1.
- registeraddress = cmd_addr[3:0]; upper bits are ignored (index 31 maps to 15).

Test Plan:
- WMEM addr 3 data 16'hEE02, then RMEM addr 3 -> status 0 on both; rsp_data 16'hEE02; memorywrite high exactly ACCESS_CYCLES cycles.
- WREG addr 0 data 11, then RREG 0 -> rsp_data 11, status 0. A forced CPU readback mismatch (stubbed MD/RD) -> status 1.
- Mem[3] = 16'hFE0F (jal), Mem[4] = 16'h800F; RUN addr 3 data 1 -> cpu_reset 1-cycle pulse with resetpc 3; rsp_data (PC) = 16'h800F; RREG 14 = 5.
- RUN with count 0 -> halts at first fetch, rsp_data = start PC. Stub CPU that never returns to state 1 -> status 2 after RUN_TIMEOUT cycles, cpu_test low afterwards.
- cmd_op 7 -> status 3, no CPU strobes. Command presented during RUN -> cmd_ready 0, command taken only after the response.
- Assert reset during ACCESS and during RUN -> all outputs at reset values asynchronously, no rsp_valid, IDLE with cmd_ready 1 after release.
